// File: rtl/cory_pkg.sv
// Shared definitions for the cory_flop register slice and the blocks that use it.
package cory_pkg;

    // Occupancy of the two-entry slice: nothing held, main only, or main plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } cory_state_t;

endpackage

// File: rtl/cory_flop.sv
// Two-entry valid/ready register slice (main + skid).
// Both the forward path (o_z_v, o_z_d) and the backward path (o_a_r) come straight
// from flops, so this slice breaks timing in both directions.
module cory_flop
    import cory_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_a_v,
    input  logic [N-1:0] i_a_d,
    output logic         o_a_r,
    output logic         o_z_v,
    output logic [N-1:0] o_z_d,
    input  logic         i_z_r
);

`ifdef SIM
    // A zero-width slice makes no sense; stop the simulation early.
    initial begin
        if (N < 1) begin
            $display("cory_flop: ERROR parameter N=%0d must be at least 1", N);
            $finish;
        end
    end
`endif

    cory_state_t state;
    cory_state_t next_state;

    logic         a_r_q;
    logic         z_v_q;
    logic [N-1:0] main_q;
    logic [N-1:0] skid_q;

    logic in_xfer;
    logic out_xfer;
    logic load_main;
    logic load_skid;
    logic main_from_skid;

    assign o_a_r = a_r_q;
    assign o_z_v = z_v_q;
    assign o_z_d = main_q;

    // Handshakes use the registered ready/valid only, so i_z_r is ignored while empty.
    assign in_xfer  = i_a_v & a_r_q;
    assign out_xfer = z_v_q & i_z_r;

    // Next occupancy and which data register loads this cycle.
    always_comb begin
        next_state     = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    next_state = ONE;
                    load_main  = 1'b1;
                end
            end
            ONE: begin
                if (in_xfer && !out_xfer) begin
                    next_state = FULL;
                    load_skid  = 1'b1;
                end else if (in_xfer && out_xfer) begin
                    load_main  = 1'b1;
                end else if (out_xfer) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    next_state     = ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                next_state = EMPTY;
            end
        endcase
    end

    // State register plus ready/valid flops decoded from the next state ahead of time.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
            a_r_q <= 1'b1;
            z_v_q <= 1'b0;
        end else begin
            state <= next_state;
            a_r_q <= (next_state != FULL);
            z_v_q <= (next_state != EMPTY);
        end
    end

    // Data registers only load when their entry is written, so unqualified data never lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= main_from_skid ? skid_q : i_a_d;
            end
            if (load_skid) begin
                skid_q <= i_a_d;
            end
        end
    end

endmodule

// File: tb/tb_cory_flop.sv
// Directed and scoreboard-checked bench for the cory_flop register slice.
module tb_cory_flop;

    localparam int N = 8;

    logic         clk;
    logic         reset;
    logic         i_a_v;
    logic [N-1:0] i_a_d;
    logic         o_a_r;
    logic         o_z_v;
    logic [N-1:0] o_z_d;
    logic         i_z_r;

    int checks = 0;
    int errors = 0;

    cory_flop #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .i_a_v (i_a_v),
        .i_a_d (i_a_d),
        .o_a_r (o_a_r),
        .o_z_v (o_z_v),
        .o_z_d (o_z_d),
        .i_z_r (i_z_r)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the upstream and downstream handshake inputs.
    task automatic applyStimulus(input logic v, input logic [N-1:0] d, input logic zr);
        i_a_v = v;
        i_a_d = d;
        i_z_r = zr;
    endtask

    // Advance one clock and land 1 ns past the edge so outputs are settled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Directed sequences first, then the random scoreboard run, then reset-while-full.
    initial begin
        logic [N-1:0] q[$];
        logic [N-1:0] exp_d;
        logic [N-1:0] held;
        logic         stall;
        logic         v;
        logic         zr;
        logic [N-1:0] d;
        int           sent;
        int           recv;
        int           cycles;

        reset = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        step();
        step();
        reset = 1'b0;
        step();
        checkOutput("reset_zv", {31'd0, o_z_v}, 32'd0);
        checkOutput("reset_ar", {31'd0, o_a_r}, 32'd1);
        checkOutput("reset_zd", {24'd0, o_z_d}, 32'd0);

        // Single word through an empty slice with downstream ready.
        applyStimulus(1'b1, 8'hA5, 1'b1);
        step();
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("single_zv", {31'd0, o_z_v}, 32'd1);
        checkOutput("single_zd", {24'd0, o_z_d}, 32'hA5);
        checkOutput("single_ar", {31'd0, o_a_r}, 32'd1);
        step();
        checkOutput("single_empty_zv", {31'd0, o_z_v}, 32'd0);

        // Fill both entries while downstream stalls, then drain.
        applyStimulus(1'b1, 8'h11, 1'b0);
        step();
        checkOutput("fill1_zd", {24'd0, o_z_d}, 32'h11);
        checkOutput("fill1_ar", {31'd0, o_a_r}, 32'd1);
        applyStimulus(1'b1, 8'h22, 1'b0);
        step();
        checkOutput("full_ar", {31'd0, o_a_r}, 32'd0);
        checkOutput("full_zv", {31'd0, o_z_v}, 32'd1);
        checkOutput("full_zd", {24'd0, o_z_d}, 32'h11);
        applyStimulus(1'b1, 8'h99, 1'b0);
        step();
        checkOutput("full_hold_zd", {24'd0, o_z_d}, 32'h11);
        checkOutput("full_hold_ar", {31'd0, o_a_r}, 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("drain1_zd", {24'd0, o_z_d}, 32'h11);
        step();
        checkOutput("drain2_zv", {31'd0, o_z_v}, 32'd1);
        checkOutput("drain2_zd", {24'd0, o_z_d}, 32'h22);
        checkOutput("drain2_ar", {31'd0, o_a_r}, 32'd1);
        step();
        checkOutput("drain_empty_zv", {31'd0, o_z_v}, 32'd0);

        // Full-rate stream: each word appears one cycle after it is offered.
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, i[N-1:0], 1'b1);
            step();
            checkOutput("stream_zv", {31'd0, o_z_v}, 32'd1);
            checkOutput("stream_zd", {24'd0, o_z_d}, i);
        end
        applyStimulus(1'b0, 8'h00, 1'b1);
        step();
        checkOutput("stream_end_zv", {31'd0, o_z_v}, 32'd0);

        // Random handshakes with a queue model of the expected output order.
        sent   = 0;
        recv   = 0;
        cycles = 0;
        while (recv < 10000 && cycles < 50000) begin
            v  = (sent < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
            zr = 1'($urandom_range(0, 1));
            d  = v ? sent[N-1:0] : N'($urandom);
            applyStimulus(v, d, zr);
            if (v && o_a_r) begin
                q.push_back(d);
                sent++;
            end
            if (o_z_v && zr) begin
                if (q.size() > 0) exp_d = q.pop_front();
                else exp_d = ~o_z_d;
                checkOutput("rand_order", {24'd0, o_z_d}, {24'd0, exp_d});
                recv++;
            end
            stall = o_z_v && !zr;
            held  = o_z_d;
            step();
            cycles++;
            if (stall) begin
                checkOutput("rand_stable_zd", {24'd0, o_z_d}, {24'd0, held});
                checkOutput("rand_stable_zv", {31'd0, o_z_v}, 32'd1);
            end
        end
        checkOutput("rand_count", recv, 32'd10000);
        checkOutput("rand_leftover", q.size(), 32'd0);

        // Reset while full must discard both stored words.
        applyStimulus(1'b1, 8'h33, 1'b0);
        step();
        applyStimulus(1'b1, 8'h44, 1'b0);
        step();
        checkOutput("prereset_ar", {31'd0, o_a_r}, 32'd0);
        reset = 1'b1;
        applyStimulus(1'b1, 8'h55, 1'b1);
        step();
        reset = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("postreset_zv", {31'd0, o_z_v}, 32'd0);
        checkOutput("postreset_ar", {31'd0, o_a_r}, 32'd1);
        checkOutput("postreset_zd", {24'd0, o_z_d}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("postreset_idle_zv", {31'd0, o_z_v}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cory_flop.md
CORY_FLOP -- requirements
Module: cory_flop

Interface
REQ-001 Parameter N, default 8: data width in bits; legal range 1..1024.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 i_a_v  input  1  upstream valid.
REQ-005 i_a_d  input  N  upstream data.
REQ-006 o_a_r  output  1  upstream ready; driven directly from a flop, no combinational path from any input.
REQ-007 o_z_v  output  1  downstream valid; driven directly from a flop.
REQ-008 o_z_d  output  N  downstream data; driven directly from a flop.
REQ-009 i_z_r  input  1  downstream ready.

Function
REQ-010 The block SHALL be a two-entry valid/ready register slice (main register plus skid register) that fully registers both the forward path and the backward path.
- Forward path: o_z_v, o_z_d.
- Backward path: o_a_r.
REQ-011 An input transfer SHALL occur on a cycle with i_a_v=1 and o_a_r=1; an output transfer SHALL occur on a cycle with o_z_v=1 and i_z_r=1.
REQ-012 State machine states: EMPTY (0 entries), ONE (main valid), FULL (main and skid valid); o_z_v=1 in ONE and FULL, and o_a_r=1 in EMPTY and ONE.
REQ-013 EMPTY: an input transfer SHALL load main and go to ONE; otherwise the block SHALL stay in EMPTY.
REQ-014 ONE, input transfer with no output transfer: the block SHALL load skid and go to FULL.
REQ-015 ONE, simultaneous input and output transfer: the block SHALL load main with i_a_d and stay in ONE.
REQ-016 ONE, output transfer only: the block SHALL go to EMPTY.
REQ-017 ONE, no transfer: the block SHALL hold.
REQ-018 FULL: no input transfer is possible; an output transfer SHALL copy skid into main and go to ONE; otherwise the block SHALL hold.
REQ-019 Latency SHALL be exactly 1 cycle from an input transfer into EMPTY to o_z_v=1.
REQ-020 Sustained throughput SHALL be 1 transfer per cycle when i_a_v=1 and i_z_r=1 continuously.
REQ-021 Data order SHALL be preserved; no word is dropped or duplicated.
REQ-022 While o_z_v=1 and i_z_r=0, o_z_d SHALL remain stable until the output transfer.
REQ-023 The value of i_a_d is ignored when i_a_v=0 or o_a_r=0; X on unqualified data SHALL NOT propagate into state.
REQ-024 The value of i_z_r is ignored when o_z_v=0.
REQ-025 Register enables SHALL be used for the data registers; no data register is written unless its entry is being loaded.

Reset
REQ-026 While reset=1 at a clk edge, the block SHALL enter EMPTY.
REQ-027 In the cycle after a reset edge: o_z_v=0, o_a_r=1, o_z_d=0, and the skid data register=0.
REQ-028 Reset asserted mid-operation SHALL discard both stored entries.
REQ-029 No input transfer SHALL be recorded on a cycle where reset=1.

Structure
REQ-030 State encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) SHALL be defined as constants in the shared package cory_pkg.
REQ-031 The block SHALL be a single module with no sub-modules; it is itself the leaf used by wider blocks.
REQ-032 Under SIM, N<1 SHALL produce an $display error and $finish.

Verification
REQ-033 Reset, then idle → o_z_v=0, o_a_r=1, o_z_d=0.
REQ-034 EMPTY, inputs 8'hA5 (1 cycle), i_z_r=1 → o_z_v=1 with o_z_d=8'hA5 on the next cycle; EMPTY the cycle after.
REQ-035 i_z_r=0; send 8'h11 then 8'h22 → FULL, o_a_r=0, o_z_d=8'h11 held; raise i_z_r → outputs 8'h11 then 8'h22 in consecutive cycles.
REQ-036 Stream 0x00..0xFF with i_a_v=1, i_z_r=1 → 256 outputs in 256 consecutive cycles after 1-cycle latency, in order.
REQ-037 Random i_a_v/i_z_r (50%) over 10k words → scoreboard exact in-order match, no loss, o_z_d stable during stalls.
REQ-038 Assert reset while FULL → next cycle o_z_v=0, o_a_r=1; stored words never appear at the output.
